// File: rtl/hlsm_pkg.sv
// hlsm_pkg
//   Shared types for the iterative differential-equation HLSM.
//   - state_t   : controller states (WAIT, LOAD, CHK, M1..M5, UPD, FINAL)
//   - mul_sel_t : operand pair steered into the single shared multiplier
//   - mul_sel() : state -> operand pair mapping used by the datapath mux
package hlsm_pkg;

    typedef enum logic [3:0] {
        S_WAIT,
        S_LOAD,
        S_CHK,
        S_M1,
        S_M2,
        S_M3,
        S_M4,
        S_M5,
        S_UPD,
        S_FINAL
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_K_X,     // t1 = K  * x
        OP_U_DX,    // t2 = u  * dx
        OP_T1_T2,   // t3 = t1 * t2
        OP_K_Y,     // t5 = K  * y
        OP_T5_DX    // t6 = t5 * dx
    } mul_sel_t;

    // Each multiply state owns exactly one product; every other state
    // leaves the multiplier idle with zero operands.
    function automatic mul_sel_t mul_sel(input state_t s);
        mul_sel_t r;
        r = OP_NONE;
        case (s)
            S_M1:    r = OP_K_X;
            S_M2:    r = OP_U_DX;
            S_M3:    r = OP_T1_T2;
            S_M4:    r = OP_K_Y;
            S_M5:    r = OP_T5_DX;
            default: r = OP_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hlsm_mul.sv
// hlsm_mul
//   Signed WIDTH x WIDTH combinational multiplier returning the low WIDTH
//   bits of the full product (two's-complement wrap, no overflow flag).
//   Ports:
//     a, b : signed operands
//     p    : low WIDTH bits of a*b
module hlsm_mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    // Evaluated at WIDTH bits: the low half of a signed product is the same
    // bit pattern as the truncated full-width signed product.
    assign p = $signed(a) * $signed(b);

endmodule

// File: rtl/hlsm_diffeq_iter.sv
// hlsm_diffeq_iter
//   Iterative HLSM for the differential-equation kernel. While x < a (signed)
//   and fewer than MAX_ITER steps have run, each step computes
//     u' = u - K*x*u*dx - K*y*dx,  y' = y + u*dx,  x' = x + dx
//   with all five products time-shared on one multiplier (M1..M5), so a
//   step costs 7 cycles (CHK, M1..M5, UPD).
//   Ports:
//     Clk, Rst        : clock (rising edge), async active-low reset
//     Start           : run request, only honoured in WAIT
//     u, x, y, dx, a  : signed initial state, step and bound
//     Done            : one-cycle completion pulse
//     Busy            : high in every state except WAIT
//     u1, x1, y1      : signed final state, held until next FINAL
//     Iter            : iterations executed in the last run
//     Limit           : last run stopped on MAX_ITER with x < a still true
module hlsm_diffeq_iter
    import hlsm_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 255,   // must be >= 1
    parameter int COEF     = 3
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            Start,
    input  logic [WIDTH-1:0]                u,
    input  logic [WIDTH-1:0]                x,
    input  logic [WIDTH-1:0]                y,
    input  logic [WIDTH-1:0]                dx,
    input  logic [WIDTH-1:0]                a,
    output logic                            Done,
    output logic                            Busy,
    output logic [WIDTH-1:0]                u1,
    output logic [WIDTH-1:0]                x1,
    output logic [WIDTH-1:0]                y1,
    output logic [$clog2(MAX_ITER+1)-1:0]   Iter,
    output logic                            Limit
);

    localparam int             IW       = $clog2(MAX_ITER+1);
    localparam logic [WIDTH-1:0] K      = WIDTH'(COEF);
    localparam logic [IW-1:0]  ITER_MAX = IW'(MAX_ITER);

    state_t state_q, state_d;

    // working registers
    logic [WIDTH-1:0] ur, xr, yr, dxr, ar;
    logic [WIDTH-1:0] t1, t2, t3, t5, t6;
    logic [IW-1:0]    it;

    // shared multiplier
    logic [WIDTH-1:0] op_a, op_b, prod;

    logic x_lt_a;
    assign x_lt_a = $signed(xr) < $signed(ar);

    assign Busy = (state_q != S_WAIT);

    // ---------------- controller ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= S_WAIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (Start) state_d = S_LOAD;
            S_LOAD:  state_d = S_CHK;
            // while-loop test: zero iterations are legal
            S_CHK:   state_d = (x_lt_a && (it < ITER_MAX)) ? S_M1 : S_FINAL;
            S_M1:    state_d = S_M2;
            S_M2:    state_d = S_M3;
            S_M3:    state_d = S_M4;
            S_M4:    state_d = S_M5;
            S_M5:    state_d = S_UPD;
            S_UPD:   state_d = S_CHK;
            S_FINAL: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // ---------------- operand steering ----------------
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (mul_sel(state_q))
            OP_K_X:   begin op_a = K;  op_b = xr;  end
            OP_U_DX:  begin op_a = ur; op_b = dxr; end
            OP_T1_T2: begin op_a = t1; op_b = t2;  end
            OP_K_Y:   begin op_a = K;  op_b = yr;  end
            OP_T5_DX: begin op_a = t5; op_b = dxr; end
            default:  begin op_a = '0; op_b = '0;  end
        endcase
    end

    hlsm_mul #(.WIDTH(WIDTH)) u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ur    <= '0;
            xr    <= '0;
            yr    <= '0;
            dxr   <= '0;
            ar    <= '0;
            t1    <= '0;
            t2    <= '0;
            t3    <= '0;
            t5    <= '0;
            t6    <= '0;
            it    <= '0;
            u1    <= '0;
            x1    <= '0;
            y1    <= '0;
            Iter  <= '0;
            Limit <= 1'b0;
            Done  <= 1'b0;
        end else begin
            // Done is only ever set on the FINAL edge, so it drops on the
            // following edge regardless of whether a new run is accepted.
            Done <= (state_q == S_FINAL);
            case (state_q)
                S_LOAD: begin
                    xr  <= x;
                    ur  <= u;
                    yr  <= y;
                    dxr <= dx;
                    ar  <= a;
                    it  <= '0;
                end
                S_M1: t1 <= prod;
                S_M2: t2 <= prod;
                S_M3: t3 <= prod;
                S_M4: t5 <= prod;
                S_M5: t6 <= prod;
                S_UPD: begin
                    ur <= ur - t3 - t6;
                    yr <= yr + t2;
                    xr <= xr + dxr;
                    it <= it + IW'(1);
                end
                S_FINAL: begin
                    u1    <= ur;
                    x1    <= xr;
                    y1    <= yr;
                    Iter  <= it;
                    // CHK only exits with x < a still true when the bound hit
                    Limit <= x_lt_a;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hlsm_diffeq_iter.md
# hlsm_diffeq_iter

Iterative, parametrised HLSM datapath for the differential-equation kernel. It repeats the per-step update u' = u − K·x·u·dx − K·y·dx, y' = y + u·dx, x' = x + dx while x < a, up to a bounded iteration count. All five products per step share one multiplier. It sits beside the single-step generated HLSMs and is driven by the same Start/Done controller handshake.

## Interface
- WIDTH, 32: signed datapath width.
- MAX_ITER, 255: iteration bound (≥1).
- COEF, 3: signed constant K (replaces the old `three` input).
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  run request, sampled only in WAIT.
- u, x, y, dx, a  in  WIDTH each  signed initial state, step and bound.
- Done  out  1  one-cycle completion pulse.
- Busy  out  1  high in every state except WAIT.
- u1, x1, y1  out  WIDTH each  signed final state.
- Iter  out  $clog2(MAX_ITER+1)  number of iterations executed.
- Limit  out  1  run ended because Iter reached MAX_ITER while x < a was still true.

## Operation
- Reset (Rst=0, async): State=WAIT; Done, u1, x1, y1, Iter, Limit and all internal registers cleared to 0.
- WAIT
  - Done<=0.
  - If Start=1: go to LOAD. Otherwise stay in WAIT.
- LOAD
  - xr<=x, ur<=u, yr<=y, dxr<=dx, ar<=a, it<=0.
  - Go to CHK.
- CHK
  - If xr<ar (signed) and it<MAX_ITER: go to M1. Otherwise go to FINAL.
  - Semantics are while-loop: zero iterations are possible.
- Multiply states, all through the shared multiplier:
  - M1: t1<=K·xr
  - M2: t2<=ur·dxr
  - M3: t3<=t1·t2
  - M4: t5<=K·yr
  - M5: t6<=t5·dxr
- UPD
  - ur<=ur−t3−t6; yr<=yr+t2; xr<=xr+dxr; it<=it+1.
  - Go to CHK.
- FINAL
  - u1<=ur, x1<=xr, y1<=yr, Iter<=it.
  - Limit<=(xr<ar).
  - Done<=1. Go to WAIT.
- Arithmetic
  - Full-width product, keep the low WIDTH bits.
  - Add/sub are two's-complement wrap.
  - No saturation; overflow is not flagged.
- Outputs u1, x1, y1, Iter and Limit hold their value until the next FINAL or reset.
- Start is ignored outside WAIT.
- Reset mid-run aborts the run: no Done, outputs cleared.

## Timing
- Edge E0 samples Start=1 in WAIT.
- An iteration costs 7 cycles: CHK, M1–M5, UPD.
- Done is high in the cycle after edge E(3+7k), where k is the number of iterations, and for exactly one cycle.
- Start=1 during the Done cycle: Done falls at the next edge and the new run is accepted at that same edge, giving back-to-back runs with no idle gap.
- Busy is high from the edge after E0 through the FINAL cycle.
- Multiplier is single-cycle combinational; each product is registered at the end of its M state.

## Structure
- Package hlsm_pkg holds:
  - state enum: WAIT, LOAD, CHK, M1–M5, UPD, FINAL.
  - multiplier operand-select enum.
- Sub-module hlsm_mul: signed WIDTH×WIDTH multiply returning the low WIDTH bits. It is instantiated once. Operands are muxed by state.

## Test plan
- Nominal (WIDTH=32, K=3):
  - Stimulus: u=1, x=0, y=0, dx=1, a=3.
  - Required: u1=19, x1=3, y1=−3, Iter=3, Limit=0, Done at E24.
- Zero iterations:
  - Stimulus: x=5, a=3, u=7, y=9.
  - Required: u1=7, x1=5, y1=9, Iter=0, Limit=0, Done at E3.
- Bound hit (MAX_ITER=4):
  - Stimulus: x=0, dx=0, a=1, u=2, y=5.
  - Required: Iter=4, Limit=1, x1=0, u1=2, y1=5, Done at E31.
- Wrap (WIDTH=8, MAX_ITER=2):
  - Stimulus: x=100, dx=100, a=127, u=0, y=0.
  - Required: x1=44, u1=0, y1=0, Iter=2, Limit=1.
- Handshake:
  - Stimulus: pulse Start again mid-run; separately, hold Start high through Done.
  - Required: the mid-run Start is ignored with no extra Done; holding Start high gives a back-to-back second run with correct results.
- Reset:
  - Stimulus: assert Rst=0 asynchronously during M3.
  - Required: all outputs 0 immediately, no Done, Busy=0; a clean run follows after release.
